// File: rtl/write_bytes_multi.sv
// Byte serializer: latches one multi-byte word and writes it one byte per clock
// into a byte-wide RAM port, with run-time byte order and per-byte enables.
module write_bytes_multi #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 8,
  parameter int PACK       = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               addr,
  input  logic [WORD_BYTES*8-1:0]         word,
  input  logic [WORD_BYTES-1:0]           byte_en,
  input  logic                            msb_first,
  output logic                            busy,
  output logic                            done,
  output logic [7:0]                      wr_data,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic                            we,
  output logic                            wrapped,
  output logic [$clog2(WORD_BYTES+1)-1:0] bytes_written
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CNT_W = $clog2(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [ADDR_W-1:0]       ptr_reg, ptr_next;
  logic [WORD_BYTES*8-1:0] word_reg, word_next;
  logic [WORD_BYTES-1:0]   en_reg, en_next;
  logic                    msb_reg, msb_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic [7:0]              wr_data_reg, wr_data_next;
  logic [ADDR_W-1:0]       wr_addr_reg, wr_addr_next;
  logic                    we_reg, we_next;
  logic                    wrapped_reg, wrapped_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;

  logic [7:0]              byte_arr [WORD_BYTES];
  logic [IDX_W-1:0]        sel;
  logic                    sel_en;

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
    assign byte_arr[gi] = word_reg[8*gi +: 8];
  end

  assign sel    = msb_reg ? (LAST_IDX - idx_reg) : idx_reg;
  assign sel_en = en_reg[sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_reg     <= '0;
      ptr_reg     <= '0;
      word_reg    <= '0;
      en_reg      <= '0;
      msb_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wr_data_reg <= '0;
      wr_addr_reg <= '0;
      we_reg      <= 1'b0;
      wrapped_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      idx_reg     <= idx_next;
      ptr_reg     <= ptr_next;
      word_reg    <= word_next;
      en_reg      <= en_next;
      msb_reg     <= msb_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      wr_data_reg <= wr_data_next;
      wr_addr_reg <= wr_addr_next;
      we_reg      <= we_next;
      wrapped_reg <= wrapped_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    ptr_next     = ptr_reg;
    word_next    = word_reg;
    en_next      = en_reg;
    msb_next     = msb_reg;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    wr_data_next = wr_data_reg;
    wr_addr_next = wr_addr_reg;
    we_next      = 1'b0;
    wrapped_next = wrapped_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      IDLE: begin
        // The done pulse is registered, so it is visible while already back
        // in IDLE; a start in that cycle must still be ignored.
        if (start && !done_reg) begin
          word_next    = word;
          en_next      = byte_en;
          msb_next     = msb_first;
          ptr_next     = addr;
          idx_next     = '0;
          wrapped_next = 1'b0;
          cnt_next     = '0;
          state_next   = WRITE;
        end
      end
      WRITE: begin
        busy_next    = 1'b1;
        wr_data_next = byte_arr[sel];
        wr_addr_next = ptr_reg;
        we_next      = sel_en;
        if ((PACK == 0) || sel_en) begin
          ptr_next = ptr_reg + ADDR_W'(1);
          if (&ptr_reg) wrapped_next = 1'b1;
        end
        if (sel_en) cnt_next = cnt_reg + CNT_W'(1);
        if (idx_reg == LAST_IDX) state_next = DONE;
        else                     idx_next   = idx_reg + IDX_W'(1);
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign wr_data       = wr_data_reg;
  assign wr_addr       = wr_addr_reg;
  assign we            = we_reg;
  assign wrapped       = wrapped_reg;
  assign bytes_written = cnt_reg;

endmodule

// File: tb/tb_write_bytes_multi.sv
// Scoreboard bench for write_bytes_multi: a PACK=1 and a PACK=0 instance share stimulus.
module tb_write_bytes_multi;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] slot;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] word = '0;
  logic [3:0]  byte_en = '0;
  logic        msb_first = 1'b0;

  logic       busy_p1, done_p1, we_p1, wrapped_p1;
  logic [7:0] wr_data_p1, wr_addr_p1;
  logic [2:0] bw_p1;
  logic       busy_p0, done_p0, we_p0, wrapped_p0;
  logic [7:0] wr_data_p0, wr_addr_p0;
  logic [2:0] bw_p0;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t exp_q[$];
  wr_t obs_q[$];

  always #5 clk = ~clk;

  write_bytes_multi #(.WORD_BYTES(4), .ADDR_W(8), .PACK(1)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .word(word),
    .byte_en(byte_en), .msb_first(msb_first), .busy(busy_p1), .done(done_p1),
    .wr_data(wr_data_p1), .wr_addr(wr_addr_p1), .we(we_p1),
    .wrapped(wrapped_p1), .bytes_written(bw_p1)
  );

  write_bytes_multi #(.WORD_BYTES(4), .ADDR_W(8), .PACK(0)) dut_p0 (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .word(word),
    .byte_en(byte_en), .msb_first(msb_first), .busy(busy_p0), .done(done_p0),
    .wr_data(wr_data_p0), .wr_addr(wr_addr_p0), .we(we_p0),
    .wrapped(wrapped_p0), .bytes_written(bw_p0)
  );

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d, input int k);
    exp_q.push_back({a, d, 8'(k)});
  endtask

  // Drives one request and records observed writes (addr, data, cycles after the start edge).
  task automatic run_op(input logic [7:0] a, input logic [31:0] w, input logic [3:0] en,
                        input logic msb, input bit p0, input int restart_k,
                        output int done_k, output int n_done, output logic [2:0] bw,
                        output logic wr, output logic [7:0] busy_seen);
    done_k = -1; n_done = 0; bw = 'x; wr = 1'bx; busy_seen = '0;
    @(negedge clk);
    start = 1'b1; addr = a; word = w; byte_en = en; msb_first = msb;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = (restart_k != 0) && (k == restart_k - 1);
      if (p0 ? we_p0 : we_p1)
        obs_q.push_back({(p0 ? wr_addr_p0 : wr_addr_p1), (p0 ? wr_data_p0 : wr_data_p1), 8'(k)});
      if (k < 8) busy_seen[k] = p0 ? busy_p0 : busy_p1;
      if (p0 ? done_p0 : done_p1) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          bw = p0 ? bw_p0 : bw_p1;
          wr = p0 ? wrapped_p0 : wrapped_p1;
        end
      end
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({busy_p1, done_p1, we_p1, wrapped_p1} !== 4'b0000 || wr_data_p1 !== 8'h00 ||
        wr_addr_p1 !== 8'h00 || bw_p1 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b we=%b wrapped=%b data=%h addr=%h bw=%0d, required all zero",
               busy_p1, done_p1, we_p1, wrapped_p1, wr_data_p1, wr_addr_p1, bw_p1);
    end else $display("[TB] reset state ok");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lsb_first;
    int dk, nd; logic [2:0] bw; logic wr; logic [7:0] bs; wr_t e, o;
    push_exp(8'h71, 8'hb5, 1); push_exp(8'h72, 8'h02, 2);
    push_exp(8'h73, 8'h4f, 3); push_exp(8'h74, 8'h91, 4);
    run_op(8'h71, 32'h914f02b5, 4'hF, 1'b0, 1'b0, 0, dk, nd, bw, wr, bs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL lsb_write: none, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL lsb_write: got %h, required %h", o, e); end
        else $display("[TB] lsb write addr=%h data=%h slot=%0d", o.addr, o.data, o.slot);
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL lsb_extra: %0d extra writes, required 0", obs_q.size()); end
    obs_q.delete();
    n_tests++; if (dk !== 5) begin n_fail++; $display("FAIL lsb_latency: done at %0d, required 5", dk); end
    n_tests++; if (bw !== 3'd4) begin n_fail++; $display("FAIL lsb_count: %0d, required 4", bw); end
    n_tests++; if (wr !== 1'b0) begin n_fail++; $display("FAIL lsb_wrapped: %b, required 0", wr); end
    n_tests++; if (bs !== 8'b0001_1110) begin n_fail++; $display("FAIL lsb_busy: %b, required 00011110", bs); end
  endtask

  task automatic test_msb_first;
    int dk, nd; logic [2:0] bw; logic wr; logic [7:0] bs; wr_t e, o;
    push_exp(8'h71, 8'h91, 1); push_exp(8'h72, 8'h4f, 2);
    push_exp(8'h73, 8'h02, 3); push_exp(8'h74, 8'hb5, 4);
    run_op(8'h71, 32'h914f02b5, 4'hF, 1'b1, 1'b0, 0, dk, nd, bw, wr, bs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL msb_write: none, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL msb_write: got %h, required %h", o, e); end
        else $display("[TB] msb write addr=%h data=%h slot=%0d", o.addr, o.data, o.slot);
      end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL msb_extra: %0d extra writes, required 0", obs_q.size()); end
    obs_q.delete();
    n_tests++; if (dk !== 5 || bw !== 3'd4) begin n_fail++; $display("FAIL msb_done: done at %0d bw=%0d, required 5 and 4", dk, bw); end
  endtask

  task automatic test_wrap;
    int dk, nd; logic [2:0] bw; logic wr; logic [7:0] bs; wr_t e, o;
    push_exp(8'hFE, 8'hb5, 1); push_exp(8'hFF, 8'h02, 2);
    push_exp(8'h00, 8'h4f, 3); push_exp(8'h01, 8'h91, 4);
    run_op(8'hFE, 32'h914f02b5, 4'hF, 1'b0, 1'b0, 0, dk, nd, bw, wr, bs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL wrap_write: none, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL wrap_write: got %h, required %h", o, e); end
        else $display("[TB] wrap write addr=%h data=%h slot=%0d", o.addr, o.data, o.slot);
      end
    end
    obs_q.delete();
    n_tests++; if (wr !== 1'b1) begin n_fail++; $display("FAIL wrap_set: wrapped=%b, required 1", wr); end
    n_tests++; if (wrapped_p1 !== 1'b1) begin n_fail++; $display("FAIL wrap_hold: wrapped=%b after done, required 1", wrapped_p1); end
    // Back-to-back start at 8'h10 must clear wrapped.
    push_exp(8'h10, 8'h44, 1); push_exp(8'h11, 8'h33, 2);
    push_exp(8'h12, 8'h22, 3); push_exp(8'h13, 8'h11, 4);
    run_op(8'h10, 32'h11223344, 4'hF, 1'b0, 1'b0, 0, dk, nd, bw, wr, bs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL clear_write: none, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL clear_write: got %h, required %h", o, e); end
        else $display("[TB] clear write addr=%h data=%h slot=%0d", o.addr, o.data, o.slot);
      end
    end
    obs_q.delete();
    n_tests++; if (wr !== 1'b0) begin n_fail++; $display("FAIL wrap_clear: wrapped=%b, required 0", wr); end
  endtask

  task automatic test_sparse;
    int dk, nd; logic [2:0] bw; logic wr; logic [7:0] bs; wr_t e, o;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin push_exp(8'h71, 8'h02, 2); push_exp(8'h72, 8'h91, 4); end
      else        begin push_exp(8'h72, 8'h02, 2); push_exp(8'h74, 8'h91, 4); end
      run_op(8'h71, 32'h914f02b5, 4'b1010, 1'b0, (p == 1), 0, dk, nd, bw, wr, bs);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_tests++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL sparse_pack%0d_write: none, required %h", 1 - p, e); end
        else begin
          o = obs_q.pop_front();
          if (o !== e) begin n_fail++; $display("FAIL sparse_pack%0d_write: got %h, required %h", 1 - p, o, e); end
          else $display("[TB] sparse PACK=%0d write addr=%h data=%h slot=%0d", 1 - p, o.addr, o.data, o.slot);
        end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL sparse_extra: %0d extra writes, required 0", obs_q.size()); end
      obs_q.delete();
      n_tests++; if (bw !== 3'd2 || dk !== 5) begin n_fail++; $display("FAIL sparse_count: bw=%0d done at %0d, required 2 and 5", bw, dk); end
    end
  endtask

  task automatic test_ignored_start;
    int dk, nd; logic [2:0] bw; logic wr; logic [7:0] bs;
    run_op(8'h20, 32'hdeadbeef, 4'hF, 1'b0, 1'b0, 2, dk, nd, bw, wr, bs);
    n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL ignore_writes: %0d writes, required 4", obs_q.size()); end
    else $display("[TB] restart ignored, 4 writes");
    obs_q.delete();
    n_tests++; if (nd != 1 || dk !== 5) begin n_fail++; $display("FAIL ignore_done: %0d dones first at %0d, required 1 at 5", nd, dk); end
  endtask

  task automatic test_all_disabled;
    int dk, nd; logic [2:0] bw; logic wr; logic [7:0] bs;
    run_op(8'h30, 32'h12345678, 4'h0, 1'b0, 1'b0, 0, dk, nd, bw, wr, bs);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL zero_en_writes: %0d writes, required 0", obs_q.size()); end
    obs_q.delete();
    n_tests++; if (dk !== 5 || bw !== 3'd0) begin n_fail++; $display("FAIL zero_en_done: done at %0d bw=%0d, required 5 and 0", dk, bw); end
    else $display("[TB] zero byte_en run done at 5 with 0 bytes");
  endtask

  task automatic test_reset_abort;
    int dk, nd, late_done; logic [2:0] bw; logic wr; logic [7:0] bs; wr_t e, o;
    @(negedge clk);
    start = 1'b1; addr = 8'h50; word = 32'haabbccdd; byte_en = 4'hF; msb_first = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (we_p1 !== 1'b1 || wr_addr_p1 !== 8'h52) begin n_fail++; $display("FAIL abort_slot2: we=%b addr=%h, required 1 and 52", we_p1, wr_addr_p1); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (we_p1 !== 1'b0 || busy_p1 !== 1'b0) begin n_fail++; $display("FAIL abort_async: we=%b busy=%b, required 0 0", we_p1, busy_p1); end
    else $display("[TB] async reset dropped we and busy");
    late_done = 0;
    repeat (3) begin @(negedge clk); if (done_p1) late_done++; end
    reset = 1'b1;
    repeat (2) begin @(negedge clk); if (done_p1) late_done++; end
    n_tests++; if (late_done != 0) begin n_fail++; $display("FAIL abort_no_done: %0d dones, required 0", late_done); end
    push_exp(8'h60, 8'hdd, 1); push_exp(8'h61, 8'hcc, 2);
    push_exp(8'h62, 8'hbb, 3); push_exp(8'h63, 8'haa, 4);
    run_op(8'h60, 32'haabbccdd, 4'hF, 1'b0, 1'b0, 0, dk, nd, bw, wr, bs);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL post_reset_write: none, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL post_reset_write: got %h, required %h", o, e); end
        else $display("[TB] post-reset write addr=%h data=%h slot=%0d", o.addr, o.data, o.slot);
      end
    end
    obs_q.delete();
    n_tests++; if (dk !== 5 || bw !== 3'd4) begin n_fail++; $display("FAIL post_reset_done: done at %0d bw=%0d, required 5 and 4", dk, bw); end
  endtask

  initial begin
    test_reset;
    test_lsb_first;
    test_msb_first;
    test_wrap;
    test_sparse;
    test_ignored_start;
    test_all_disabled;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
